// File: rtl/twf_pkg.sv
// Shared types and constants for the twiddle ROM fetch path.
package twf_pkg;

    localparam int TW_NUM_GRP = 32;
    localparam int TW_GRP_W   = 5;
    localparam int TW_LANES   = 16;
    localparam int TW_DATA_W  = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FIN    = 2'd2
    } twf_seq_state_e;

    typedef logic [TW_GRP_W-1:0] tw_grp_t;

endpackage

// File: rtl/twf_fetch_seq.sv
// Group-index sequencer for the registered twiddle ROM bank; keeps tw_valid
// aligned with the ROM's 1-cycle output register under full backpressure.
//
// state  | meaning
// IDLE   | no pass; waiting for start
// STREAM | ROM outputs hold group tw_grp, tw_valid high
// FIN    | single cycle with done high after the last accept
module twf_fetch_seq
    import twf_pkg::*;
#(
    parameter  int NUM_GRP = TW_NUM_GRP,
    parameter  int CNT_W   = 6,
    localparam int GRP_W   = $clog2(NUM_GRP)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [GRP_W-1:0] cfg_first,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             tw_ready,
    output logic [GRP_W-1:0] grp_idx,
    output logic             tw_valid,
    output logic [GRP_W-1:0] tw_grp,
    output logic             tw_last,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [CNT_W-1:0] NUM_CNT = CNT_W'(NUM_GRP);

    twf_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] n_clamp;
    logic [GRP_W-1:0] grp_d;
    logic             valid_d, last_d, busy_d, done_d, aborted_d;
    logic             accept;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        grp_d     = tw_grp;
        valid_d   = tw_valid;
        aborted_d = 1'b0;
        grp_idx   = tw_grp;
        accept    = tw_valid & tw_ready;
        n_clamp   = (cfg_count > NUM_CNT) ? NUM_CNT : cfg_count;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (n_clamp == '0) begin
                        state_d = FIN;
                    end else begin
                        // ROM register captures the first group this cycle
                        grp_idx = cfg_first;
                        grp_d   = cfg_first;
                        rem_d   = n_clamp;
                        valid_d = 1'b1;
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (abort) begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    rem_d     = '0;
                    aborted_d = 1'b1;
                end else if (accept) begin
                    if (rem_q == CNT_W'(1)) begin
                        state_d = FIN;
                        valid_d = 1'b0;
                        rem_d   = '0;
                    end else begin
                        grp_idx = tw_grp + 1'b1;
                        grp_d   = tw_grp + 1'b1;
                        rem_d   = rem_q - 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                rem_d   = '0;
            end
        endcase

        busy_d = (state_d == STREAM);
        done_d = (state_d == FIN);
        last_d = valid_d && (rem_d == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            tw_grp   <= '0;
            tw_valid <= 1'b0;
            tw_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            tw_grp   <= grp_d;
            tw_valid <= valid_d;
            tw_last  <= last_d;
            busy     <= busy_d;
            done     <= done_d;
            aborted  <= aborted_d;
        end
    end

endmodule

// File: tb/tb_twf_fetch_seq.sv
// Directed plus randomized bench for twf_fetch_seq against a queue-based
// model of the pass (list of groups still to be delivered).
module tb_twf_fetch_seq;

    localparam int NG = 32;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] cfg_first = '0;
    logic [5:0] cfg_count = '0;
    logic       tw_ready = 1'b0;
    logic [4:0] grp_idx;
    logic       tw_valid;
    logic [4:0] tw_grp;
    logic       tw_last;
    logic       busy;
    logic       done;
    logic       aborted;

    twf_fetch_seq dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .cfg_first(cfg_first), .cfg_count(cfg_count), .tw_ready(tw_ready),
        .grp_idx(grp_idx), .tw_valid(tw_valid), .tw_grp(tw_grp),
        .tw_last(tw_last), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model: groups still owed in this pass; front is what the ROM shows
    int q[$];
    int cur_grp;
    bit m_done;
    bit m_aborted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur_grp   = 0;
        m_done    = 1'b0;
        m_aborted = 1'b0;
    endtask

    task automatic check_all(input bit s, input bit a, input bit r, input int f, input int c);
        int exp_idx;
        int n;
        bit idle;
        idle = (q.size() == 0) && !m_done;
        n = (c > NG) ? NG : c;
        exp_idx = cur_grp;
        if (!a) begin
            if (idle && s && n > 0) exp_idx = f;
            else if (q.size() > 1 && r) exp_idx = q[1];
        end
        chk("tw_valid", 32'(tw_valid), 32'(q.size() > 0));
        chk("tw_grp",   32'(tw_grp),   32'(cur_grp));
        chk("tw_last",  32'(tw_last),  32'(q.size() == 1));
        chk("busy",     32'(busy),     32'(q.size() > 0));
        chk("done",     32'(done),     32'(m_done));
        chk("aborted",  32'(aborted),  32'(m_aborted));
        chk("grp_idx",  32'(grp_idx),  32'(exp_idx));
    endtask

    task automatic model_step(input bit s, input bit a, input bit r, input int f, input int c);
        int n;
        bit idle;
        bit was_valid;
        idle = (q.size() == 0) && !m_done;
        was_valid = (q.size() > 0);
        n = (c > NG) ? NG : c;
        m_done    = 1'b0;
        m_aborted = 1'b0;
        if (a) begin
            if (was_valid) m_aborted = 1'b1;
            q.delete();
        end else if (idle && s) begin
            if (n == 0) m_done = 1'b1;
            else begin
                for (int i = 0; i < n; i++) q.push_back((f + i) % NG);
                cur_grp = f;
            end
        end else if (was_valid && r) begin
            void'(q.pop_front());
            if (q.size() == 0) m_done = 1'b1;
            else cur_grp = q[0];
        end
    endtask

    task automatic cycle(input bit s, input bit a, input bit r, input int f, input int c);
        @(negedge clk);
        start = s; abort = a; tw_ready = r;
        cfg_first = 5'(f); cfg_count = 6'(c);
        #1;
        check_all(s, a, r, f, c);
        model_step(s, a, r, f, c);
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int k, input bit r);
        for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, r, 0, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(tw_valid), 0);
        chk({tag, "_grp"},   32'(tw_grp),   0);
        chk({tag, "_last"},  32'(tw_last),  0);
        chk({tag, "_busy"},  32'(busy),     0);
        chk({tag, "_done"},  32'(done),     0);
        chk({tag, "_abrt"},  32'(aborted),  0);
        chk({tag, "_idx"},   32'(grp_idx),  0);
    endtask

    initial begin
        int bp[5];
        model_reset();
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rstn = 1'b1;

        // full sweep
        cycle(1, 0, 1, 0, 32);
        idle_cycles(35, 1'b1);

        // wrap-around
        cycle(1, 0, 1, 30, 4);
        idle_cycles(6, 1'b1);

        // backpressure 1,0,0,1,1
        bp = '{1, 0, 0, 1, 1};
        cycle(1, 0, 1, 5, 3);
        for (int i = 0; i < 5; i++) cycle(0, 0, bp[i][0], 0, 0);
        idle_cycles(3, 1'b1);

        // degenerate counts
        cycle(1, 0, 1, 7, 0);
        idle_cycles(3, 1'b1);
        cycle(1, 0, 1, 3, 40);
        idle_cycles(35, 1'b1);

        // abort after 3 accepts
        cycle(1, 0, 1, 0, 32);
        idle_cycles(3, 1'b1);
        cycle(0, 1, 1, 0, 0);
        idle_cycles(3, 1'b1);

        // start during STREAM ignored
        cycle(1, 0, 1, 0, 5);
        cycle(1, 0, 1, 20, 2);
        cycle(1, 0, 0, 20, 2);
        idle_cycles(7, 1'b1);

        // abort + start in IDLE
        cycle(1, 1, 1, 9, 4);
        idle_cycles(3, 1'b1);

        // async reset mid-stream at tw_grp=12
        cycle(1, 0, 1, 10, 32);
        idle_cycles(2, 1'b1);
        @(negedge clk);
        chk("pre_rst_grp", 32'(tw_grp), 12);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        cycle(1, 0, 1, 17, 6);
        idle_cycles(9, 1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 6) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
                  $urandom % NG, $urandom_range(0, 40));
        end
        idle_cycles(40, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
